seqgen_tx: RTL and testbench
============================

Name: seqgen_tx

Overview:
- Serial frame transmitter; the sending end of the prtx single-bit line that the team's 101010 sequence detector watches.
- On a start request it emits a fixed 6-bit preamble 1,0,1,0,1,0, then a DATA_W-bit payload MSB first, then GAP idle bits.
- Sits between a byte-wide producer and the serial link, one bit per clock.

Parameters:
- DATA_W, 8, payload width in bits; legal range 1..32.
- GAP, 2, number of forced-0 idle bits after the payload with the block still busy; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled only while ready=1.
- din  input  DATA_W  payload; captured on the edge that accepts start.
- prtx  output  1  serial line; registered output; 0 when idle.
- ready  output  1  high only in IDLE; start is accepted when start=1 and ready=1.
- busy  output  1  inverse of ready.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, prtx=0, done=0, bit counter=0, shift register=0. ready=1 and busy=0 as soon as rst is low.
- Reset mid-frame: prtx drops to 0 immediately. The frame is discarded and not resumed after reset.
- States and transitions:
  - IDLE: on an edge with start=1, capture din into the shift register, go to PRE, counter=0.
  - PRE: drive preamble bit[counter] from the pattern 1,0,1,0,1,0. After counter=5, go to DATA with counter=0.
  - DATA: drive shift register bit DATA_W-1, then shift left each cycle. After DATA_W bits, go to GAP, or to IDLE if GAP=0.
  - GAP: prtx=0 for GAP cycles, then go to IDLE.
- Latency: start accepted at edge k gives prtx=1 (first preamble bit) during cycle k+1.
  - Preamble occupies cycles k+1..k+6.
  - Payload occupies cycles k+7..k+6+DATA_W.
  - Gap occupies the next GAP cycles.
  - ready returns high in cycle k+7+DATA_W+GAP.
- done is high for exactly one cycle: the first cycle after the last payload bit. That cycle is the first GAP cycle, or the IDLE cycle when GAP=0.
- Start handling:
  - start while busy is ignored; no queueing, no error flag.
  - din changes after acceptance have no effect on the frame in flight.
- Back-to-back frames: start held high continuously gives frames separated by GAP zero bits plus exactly one IDLE cycle (prtx=0).
  - Minimum frame period is 6+DATA_W+GAP+1 cycles.
- Counter width is clog2(max(6,DATA_W,GAP)+1) bits; the counter never wraps inside a state.
- All outputs are driven from registers or decoded from state only; there is no combinational path from start or din to prtx.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, release, leave start=0 for 10 cycles → prtx=0, ready=1, busy=0, done=0 throughout.
- Single frame, DATA_W=8, GAP=2: pulse start with din=8'hC5 at edge k → prtx over cycles k+1..k+14 = 1,0,1,0,1,0,1,1,0,0,0,1,0,1; then 0,0; done high only in k+15; ready high again at k+17.
- Loopback to the detector: drive the sequence detector's input from prtx with din=8'h00 → detector output pulses once, in cycle k+6 (the last preamble bit), and not during the payload.
- Start ignored while busy: pulse start at k with din=8'hFF, pulse again at k+4 with din=8'h00 → exactly one frame with payload 11111111, no second frame, one done pulse.
- Back-to-back, GAP=0: hold start=1 with din=8'hA5 across two frames → frames of 14 bits separated by exactly one prtx=0 IDLE cycle, done once per frame, period 15 cycles.
- Reset mid-frame: assert rst=0 asynchronously (between clock edges) during payload bit 3 → prtx=0 and ready=1 immediately. After release, a new start with din=8'h3C gives a complete, correct frame.

Source files
------------

// File: rtl/seqgen_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seqgen_tx : serial frame transmitter (101010 preamble, MSB-first data) |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module seqgen_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              prtx,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  localparam int c_max_a = (DATA_W > 6) ? DATA_W : 6;
  localparam int c_max_b = (GAP > c_max_a) ? GAP : c_max_a;
  localparam int CW      = $clog2(c_max_b + 1);

  localparam logic [CW-1:0] c_pre_last  = CW'(5);
  localparam logic [CW-1:0] c_data_last = CW'(DATA_W - 1);
  localparam logic [CW-1:0] c_gap_last  = CW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_pre  = 2'd1;
  localparam logic [1:0] c_st_data = 2'd2;
  localparam logic [1:0] c_st_gap  = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_shl;
  logic              r_prtx, w_prtx_nxt;
  logic              r_done, w_done_nxt;

  assign w_shl = r_shift << 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_shift <= '0;
      r_prtx  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_prtx  <= w_prtx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_state_nxt = c_st_pre;
          w_cnt_nxt   = '0;
          w_shift_nxt = din;
        end
      end
      c_st_pre: begin
        if (r_cnt == c_pre_last) begin
          w_state_nxt = c_st_data;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      c_st_data: begin
        w_shift_nxt = w_shl;
        if (r_cnt == c_data_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (GAP == 0) ? c_st_idle : c_st_gap;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      c_st_gap: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // prtx is precomputed one cycle ahead so the line itself comes straight from a flop.
  // Preamble bit n is ~n[0], so the bit following count n is n[0].
  always_comb begin
    w_prtx_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      c_st_idle: w_prtx_nxt = start;
      c_st_pre:  w_prtx_nxt = (r_cnt == c_pre_last) ? r_shift[DATA_W-1] : r_cnt[0];
      c_st_data: begin
        if (r_cnt == c_data_last) w_done_nxt = 1'b1;
        else                      w_prtx_nxt = w_shl[DATA_W-1];
      end
      default: w_prtx_nxt = 1'b0;
    endcase
  end

  assign prtx  = r_prtx;
  assign done  = r_done;
  assign ready = (r_state == c_st_idle);
  assign busy  = ~ready;

endmodule
`default_nettype wire

// File: tb/tb_seqgen_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_seqgen_tx : directed self-checking bench for seqgen_tx              |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_seqgen_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       prtx, ready, busy, done;
  logic       start0 = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic       prtx0, ready0, busy0, done0;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] plog, dlog, rlog, blog, plog0, dlog0, rlog0;
  int det_cnt, det_at;

  always #5 clk = ~clk;

  seqgen_tx #(.DATA_W(8), .GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .prtx(prtx), .ready(ready), .busy(busy), .done(done)
  );

  seqgen_tx #(.DATA_W(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .din(din0),
    .prtx(prtx0), .ready(ready0), .busy(busy0), .done(done0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Index i of each log is cycle k+i, where edge k is the first edge after the call.
  // A second start pulse is raised for edge k+repulse when repulse > 0.
  task automatic run(input int n, input int repulse, input logic [7:0] rdin);
    logic [5:0] hist;
    hist = '0;
    plog = '0; dlog = '0; rlog = '0; blog = '0;
    plog0 = '0; dlog0 = '0; rlog0 = '0;
    det_cnt = 0; det_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      start = (i == repulse);
      if (i == repulse) din = rdin;
      plog[i] = prtx; dlog[i] = done; rlog[i] = ready; blog[i] = busy;
      plog0[i] = prtx0; dlog0[i] = done0; rlog0[i] = ready0;
      hist = {hist[4:0], prtx};
      if (hist == 6'b101010) begin
        det_cnt++;
        if (det_at < 0) det_at = i;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [13:0] seq);
    int ndone;
    ndone = 0;
    for (int i = 1; i <= 18; i++) begin
      check($sformatf("%s_prtx[k+%0d]", tag, i), 32'(plog[i]), 32'((i <= 14) ? seq[14-i] : 1'b0));
      check($sformatf("%s_rdy[k+%0d]", tag, i), 32'({rlog[i], blog[i]}), (i >= 17) ? 32'b10 : 32'b01);
      if (dlog[i]) ndone++;
    end
    check({tag, "_done_at15"}, 32'(dlog[15]), 32'd1);
    check({tag, "_done_count"}, 32'(ndone), 32'd1);
  endtask

  initial begin
    logic [13:0] seq;
    int ndone;

    // reset and idle
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({prtx, ready, busy, done}), 32'b0100);
    check("rst_outputs0", 32'({prtx0, ready0, busy0, done0}), 32'b0100);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle[%0d]", i), 32'({prtx, ready, busy, done}), 32'b0100);
    end

    // single frame C5
    start = 1'b1; din = 8'hC5;
    run(18, 0, 8'h00);
    seq = 14'b101010_11000101;
    check_frame("c5", seq);
    repeat (3) @(posedge clk);

    // loopback into a 101010 detector model with an all-zero payload
    #1; start = 1'b1; din = 8'h00;
    run(18, 0, 8'h00);
    check("loop_det_count", 32'(det_cnt), 32'd1);
    check("loop_det_cycle", 32'(det_at), 32'd6);
    seq = 14'b101010_00000000;
    check_frame("z", seq);
    repeat (3) @(posedge clk);

    // second start while busy is ignored
    #1; start = 1'b1; din = 8'hFF;
    run(34, 4, 8'h00);
    ndone = 0;
    seq = 14'b101010_11111111;
    for (int i = 1; i <= 34; i++) begin
      check($sformatf("busy_prtx[k+%0d]", i), 32'(plog[i]), 32'((i <= 14) ? seq[14-i] : 1'b0));
      if (dlog[i]) ndone++;
    end
    check("busy_done_count", 32'(ndone), 32'd1);
    check("busy_ready_back", 32'(rlog[17]), 32'd1);
    repeat (3) @(posedge clk);

    // back-to-back frames on the GAP=0 instance
    #1; start0 = 1'b1; din0 = 8'hA5;
    run(30, 0, 8'h00);
    start0 = 1'b0;
    seq = 14'b101010_10100101;
    for (int i = 1; i <= 30; i++) begin
      logic ep;
      ep = (i <= 14) ? seq[14-i] : (i >= 16 && i <= 29) ? seq[29-i] : 1'b0;
      check($sformatf("b2b_prtx[k+%0d]", i), 32'(plog0[i]), 32'(ep));
      check($sformatf("b2b_done[k+%0d]", i), 32'(dlog0[i]), 32'(i == 15 || i == 30));
      check($sformatf("b2b_rdy[k+%0d]", i), 32'(rlog0[i]), 32'(i == 15 || i == 30));
    end
    repeat (20) @(posedge clk);

    // asynchronous reset during payload bit 3
    #1; start = 1'b1; din = 8'hFF;
    run(10, 0, 8'h00);
    check("mid_prtx_before", 32'(prtx), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_now", 32'({prtx, ready, busy, done}), 32'b0100);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    check("mid_after_release", 32'({prtx, ready, busy, done}), 32'b0100);
    start = 1'b1; din = 8'h3C;
    run(18, 0, 8'h00);
    seq = 14'b101010_00111100;
    check_frame("3c", seq);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
